// File: rtl/rv32i_dataportarbiter.sv
// Two-master arbiter for the shared data port of the instruction/data RAM.
// Master 0 is the load/store unit; master 1 is the loader/debug master.
module rv32i_dataportarbiter #(
  parameter int unsigned ADDR_WIDTH   = 15,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [3:0]            m0_be,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [31:0]           m0_wdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [3:0]            m1_be,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [31:0]           m1_wdata,
  input  logic                  m1_lock,
  output logic                  m0_gnt,
  output logic                  m1_gnt,
  output logic                  m0_rvalid,
  output logic                  m1_rvalid,
  output logic [31:0]           m0_rdata,
  output logic [31:0]           m1_rdata,
  output logic [ADDR_WIDTH-1:0] d_addr,
  output logic                  d_we,
  output logic [3:0]            d_be,
  output logic [31:0]           d_wdata,
  input  logic [31:0]           d_rdata
);

  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  typedef enum logic {ARB, LOCK1} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} owner_e;

  state_e     state_q, state_d;
  owner_e     owner_q, owner_d;
  logic       is_read_q, is_read_d;
  logic [7:0] starve_q, starve_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB;
      owner_q   <= OWN_NONE;
      is_read_q <= 1'b0;
      starve_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      is_read_q <= is_read_d;
      starve_q  <= starve_d;
    end
  end

  // Grant is gated by rst_n so the port is quiet while reset is asserted.
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    owner_d   = OWN_NONE;
    is_read_d = 1'b0;
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    if (rst_n) begin
      case (state_q)
        ARB: begin
          if (m1_req && (!m0_req || (starve_q == STARVE_MAX))) begin
            m1_gnt = 1'b1;
          end else if (m0_req) begin
            m0_gnt = 1'b1;
          end
          if (m1_gnt && m1_lock) begin
            state_d = LOCK1;
          end
        end
        LOCK1: begin
          m1_gnt = m1_req;
          if (!m1_lock) begin
            state_d = ARB;
          end
        end
        default: state_d = ARB;
      endcase

      if (m1_gnt) begin
        starve_d = 8'd0;
      end else if (m1_req && (starve_q != STARVE_MAX)) begin
        starve_d = starve_q + 8'd1;
      end

      if (m0_gnt) begin
        owner_d   = OWN_M0;
        is_read_d = !m0_we;
      end else if (m1_gnt) begin
        owner_d   = OWN_M1;
        is_read_d = !m1_we;
      end
    end
  end

  // With no grant the address/data mux rests on master 0.
  always_comb begin
    d_addr  = m1_gnt ? m1_addr  : m0_addr;
    d_wdata = m1_gnt ? m1_wdata : m0_wdata;
    d_we    = (m0_gnt && m0_we) || (m1_gnt && m1_we);
    d_be    = m0_gnt ? m0_be : (m1_gnt ? m1_be : 4'b0000);
  end

  always_comb begin
    m0_rvalid = (owner_q == OWN_M0);
    m1_rvalid = (owner_q == OWN_M1);
    m0_rdata  = (m0_rvalid && is_read_q) ? d_rdata : 32'd0;
    m1_rdata  = (m1_rvalid && is_read_q) ? d_rdata : 32'd0;
  end

endmodule

// File: tb/tb_rv32i_dataportarbiter.sv
// Bench for rv32i_dataportarbiter: directed scenarios plus a random phase,
// checked against a rule-level model with a shadow memory.
module tb_rv32i_dataportarbiter;

  localparam int unsigned AW  = 15;
  localparam int unsigned LIM = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [3:0]    m0_be, m1_be;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [31:0]   m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0]   m0_rdata, m1_rdata;
  logic [AW-1:0] d_addr;
  logic          d_we;
  logic [3:0]    d_be;
  logic [31:0]   d_wdata;
  logic [31:0]   d_rdata = 32'd0;

  always #5 clk = ~clk;

  rv32i_dataportarbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .d_addr(d_addr), .d_we(d_we), .d_be(d_be), .d_wdata(d_wdata), .d_rdata(d_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 16) return 32'h12345678;
    if (i == 5)  return 32'h11223344;
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5AA5A5;
  endfunction

  // Synchronous RAM data port: one-cycle registered read, byte-lane writes.
  logic [31:0] ram [0:255];
  logic        load;
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
    end else begin
      if (d_we)
        for (int i = 0; i < 4; i++)
          if (d_be[i]) ram[d_addr[7:0]][8*i +: 8] <= d_wdata[8*i +: 8];
      d_rdata <= ram[d_addr[7:0]];
    end
  end

  logic [31:0] shadow [0:255];
  int          starve;
  bit          locked;
  int          prev_owner;
  bit          prev_read;
  logic [31:0] prev_data;
  bit          exp_g0, exp_g1;
  logic        last_g0, last_g1, last_m1_rvalid;
  logic [31:0] last_m0_rdata, last_m1_rdata;
  int          n_assert = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_m0(input logic req, input logic we, input logic [3:0] be,
                        input int addr, input logic [31:0] wd);
    m0_req = req; m0_we = we; m0_be = be; m0_addr = AW'(addr); m0_wdata = wd;
  endtask

  task automatic set_m1(input logic req, input logic we, input logic [3:0] be,
                        input int addr, input logic [31:0] wd, input logic lock);
    m1_req = req; m1_we = we; m1_be = be; m1_addr = AW'(addr); m1_wdata = wd; m1_lock = lock;
  endtask

  task automatic model_reset();
    starve = 0; locked = 0; prev_owner = 0; prev_read = 0; prev_data = 32'd0;
  endtask

  // Called just after a falling edge with inputs set; ends at the next falling edge.
  task automatic cycle();
    logic [AW-1:0] a;
    logic [31:0]   wd;
    logic          we;
    logic [3:0]    be;
    if (locked) begin
      exp_g1 = m1_req;
      exp_g0 = 1'b0;
    end else begin
      exp_g1 = m1_req && (!m0_req || starve == LIM);
      exp_g0 = m0_req && !exp_g1;
    end
    a  = exp_g1 ? m1_addr  : m0_addr;
    wd = exp_g1 ? m1_wdata : m0_wdata;
    we = exp_g0 ? m0_we : (exp_g1 ? m1_we : 1'b0);
    be = exp_g0 ? m0_be : (exp_g1 ? m1_be : 4'b0000);
    #1;
    last_g0 = m0_gnt; last_g1 = m1_gnt; last_m1_rvalid = m1_rvalid;
    last_m0_rdata = m0_rdata; last_m1_rdata = m1_rdata;
    chk("m0_gnt", 32'(m0_gnt), 32'(exp_g0));
    chk("m1_gnt", 32'(m1_gnt), 32'(exp_g1));
    chk("d_we", 32'(d_we), 32'(we));
    chk("d_be", 32'(d_be), 32'(be));
    chk("d_addr", 32'(d_addr), 32'(a));
    chk("d_wdata", d_wdata, wd);
    chk("m0_rvalid", 32'(m0_rvalid), 32'(prev_owner == 1));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(prev_owner == 2));
    if (prev_owner != 1) chk("m0_rdata_idle", m0_rdata, 32'd0);
    else if (prev_read)  chk("m0_rdata", m0_rdata, prev_data);
    if (prev_owner != 2) chk("m1_rdata_idle", m1_rdata, 32'd0);
    else if (prev_read)  chk("m1_rdata", m1_rdata, prev_data);

    prev_owner = exp_g0 ? 1 : (exp_g1 ? 2 : 0);
    prev_read  = (exp_g0 || exp_g1) && !we;
    prev_data  = shadow[a[7:0]];
    if (we)
      for (int i = 0; i < 4; i++)
        if (be[i]) shadow[a[7:0]][8*i +: 8] = wd[8*i +: 8];
    if (exp_g1) starve = 0;
    else if (m1_req && starve < LIM) starve++;
    locked = locked ? m1_lock : (exp_g1 && m1_lock);
    @(negedge clk);
  endtask

  task automatic idle();
    set_m0(0, 0, 4'h0, 0, 32'd0);
    set_m1(0, 0, 4'h0, 0, 32'd0, 0);
  endtask

  initial begin
    logic [7:0] pat;
    rst_n = 1'b0;
    load  = 1'b1;
    set_m0(1, 1, 4'hF, 3, 32'hDEADBEEF);
    set_m1(1, 1, 4'hF, 4, 32'hCAFEF00D, 1);
    for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
    repeat (2) @(negedge clk);
    load = 1'b0;
    #1;
    chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
    chk("rst_m1_gnt", 32'(m1_gnt), 32'd0);
    chk("rst_d_we", 32'(d_we), 32'd0);
    chk("rst_d_be", 32'(d_be), 32'd0);
    chk("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
    chk("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    model_reset();

    // Single read
    set_m0(1, 0, 4'hF, 16, 32'd0);
    cycle();
    idle();
    cycle();
    chk("single_rdata", last_m0_rdata, 32'h12345678);
    chk("single_m1_rvalid", 32'(last_m1_rvalid), 32'd0);

    // Byte write then read-back
    set_m1(1, 1, 4'b0010, 5, 32'hAABBCCDD, 0);
    cycle();
    set_m1(1, 0, 4'hF, 5, 32'd0, 0);
    cycle();
    idle();
    cycle();
    chk("bytewrite_rdata", last_m1_rdata, 32'h1122CC44);

    // Continuous contention: m1 wins every fourth cycle
    set_m0(1, 0, 4'hF, 8, 32'd0);
    set_m1(1, 0, 4'hF, 9, 32'd0, 0);
    pat = 8'b1000_1000;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("contention_m1_gnt", 32'(last_g1), 32'(pat[i]));
      chk("contention_one_hot", 32'(last_g0 ^ last_g1), 32'd1);
    end
    idle();
    cycle();

    // Lock: four locked m1 accesses, m0 waits one more cycle after unlock
    set_m1(1, 0, 4'hF, 3, 32'd0, 1);
    cycle();
    chk("lock_first_m1", 32'(last_g1), 32'd1);
    set_m0(1, 0, 4'hF, 7, 32'd0);
    for (int i = 0; i < 3; i++) begin
      set_m1(1, 1, 4'hF, 4 + i, $urandom, 1);
      cycle();
      chk("lock_m0_blocked", 32'(last_g0), 32'd0);
      chk("lock_m1_held", 32'(last_g1), 32'd1);
    end
    set_m1(0, 0, 4'h0, 0, 32'd0, 0);
    cycle();
    chk("unlock_edge_m0", 32'(last_g0), 32'd0);
    cycle();
    chk("after_unlock_m0", 32'(last_g0), 32'd1);
    idle();
    cycle();

    // Reset in the cycle after a read grant, with starve_cnt nonzero
    set_m0(1, 0, 4'hF, 16, 32'd0);
    set_m1(1, 0, 4'hF, 9, 32'd0, 0);
    cycle();
    cycle();
    rst_n = 1'b0;
    #1;
    chk("midrst_m0_rvalid", 32'(m0_rvalid), 32'd0);
    chk("midrst_m0_rdata", m0_rdata, 32'd0);
    chk("midrst_m1_rdata", m1_rdata, 32'd0);
    chk("midrst_m0_gnt", 32'(m0_gnt), 32'd0);
    chk("midrst_m1_gnt", 32'(m1_gnt), 32'd0);
    chk("midrst_d_we", 32'(d_we), 32'd0);
    chk("midrst_d_be", 32'(d_be), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    pat = 8'b0000_1000;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("postrst_m1_gnt", 32'(last_g1), 32'(pat[i]));
    end
    idle();
    cycle();

    // Random traffic, requests held until granted
    for (int n = 0; n < 400; n++) begin
      if (!m0_req || exp_g0)
        set_m0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
               $urandom_range(0, 15), $urandom);
      if (!m1_req || exp_g1)
        set_m1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
               $urandom_range(0, 15), $urandom, m1_lock);
      m1_lock = ($urandom_range(0, 2) == 0);
      cycle();
    end
    idle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
